// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and register map for the convolution sequencer.
package conv_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StDone
    } conv_state_e;

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegCfg    = 2'd1;
    localparam logic [1:0] RegIrqClr = 2'd2;
    localparam logic [1:0] RegPixCnt = 2'd3;

    localparam int unsigned CtrlStartBit  = 0;
    localparam int unsigned CtrlAbortBit  = 1;
    localparam int unsigned CtrlIrqEnBit  = 2;
    localparam int unsigned IrqClrDoneBit = 0;
    localparam int unsigned IrqClrErrBit  = 1;

    function automatic logic [31:0] pack_status(input logic irq_en, input logic err,
                                                input logic done, input logic busy);
        return {28'b0, irq_en, err, done, busy};
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// APB slave bus bundle for the convolution sequencer.
interface conv_seq_ctrl_if;

    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/conv_seq_ctrl_pix_counter.sv
// Row/column position tracker for a raster-ordered pixel stream.
module conv_seq_ctrl_pix_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] height_i,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o,
    output logic             last_o
);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             col_wrap;

    assign col_wrap = (col_q == width_i - CNT_W'(1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = col_wrap & (row_q == height_i - CNT_W'(1));

endmodule

// File: rtl/conv_seq_ctrl.sv
// APB-programmed sequencer: streams an image, flags KxK windows, drains the MAC pipe, reports done.
module conv_seq_ctrl
    import conv_seq_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W    = 28,
    parameter int unsigned IMG_H    = 28,
    parameter int unsigned K        = 3,
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    conv_seq_ctrl_if.slave   apb,
    output logic             irq_o,
    output logic             pic_req_o,
    input  logic             pic_valid_i,
    output logic             eng_clr_o,
    output logic             win_valid_o,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o
);

    localparam int unsigned DrainW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int unsigned PixW   = 2 * CNT_W;

    conv_state_e         state_q;
    logic                pic_req_q;
    logic                eng_clr_q;
    logic [DrainW-1:0]   drain_q;
    logic                done_q;
    logic                err_q;
    logic                irq_en_q;
    logic [CNT_W-1:0]    width_q;
    logic [CNT_W-1:0]    height_q;
    logic [PixW-1:0]     pixcnt_q;

    logic                wr_en, rd_en;
    logic [1:0]          reg_sel;
    logic                ctrl_wr, cfg_wr, irqclr_wr;
    logic                start_req, abort_req;
    logic                busy, dims_ok, accept, last_pix;
    logic                done_set, err_set;
    logic [31:0]         prdata;

    assign wr_en     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_en     = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign reg_sel   = apb.PADDR[3:2];
    assign ctrl_wr   = wr_en & (reg_sel == RegCtrl);
    assign cfg_wr    = wr_en & (reg_sel == RegCfg);
    assign irqclr_wr = wr_en & (reg_sel == RegIrqClr);

    // Abort suppresses a start carried in the same write.
    assign abort_req = ctrl_wr & apb.PWDATA[CtrlAbortBit];
    assign start_req = ctrl_wr & apb.PWDATA[CtrlStartBit] & ~apb.PWDATA[CtrlAbortBit];

    assign busy     = (state_q != StIdle);
    assign dims_ok  = (width_q != '0) & (height_q != '0);
    assign accept   = pic_req_q & pic_valid_i;
    assign done_set = (state_q == StDone) & ~abort_req;
    assign err_set  = (abort_req & busy) | (start_req & (busy | ~dims_ok));

    conv_seq_ctrl_pix_counter #(
        .CNT_W (CNT_W)
    ) u_pix_counter (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .clr_i    (state_q == StClear),
        .inc_i    (accept),
        .width_i  (width_q),
        .height_i (height_q),
        .row_o    (row_o),
        .col_o    (col_o),
        .last_o   (last_pix)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= StIdle;
            pic_req_q <= 1'b0;
            eng_clr_q <= 1'b0;
            drain_q   <= '0;
        end else begin
            eng_clr_q <= 1'b0;
            if (abort_req && busy) begin
                state_q   <= StIdle;
                pic_req_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_req && dims_ok) begin
                            state_q   <= StClear;
                            eng_clr_q <= 1'b1;
                        end
                    end
                    StClear: begin
                        state_q   <= StStream;
                        pic_req_q <= 1'b1;
                    end
                    StStream: begin
                        if (accept && last_pix) begin
                            state_q   <= StDrain;
                            pic_req_q <= 1'b0;
                            drain_q   <= '0;
                        end
                    end
                    StDrain: begin
                        if (drain_q == DrainW'(PIPE_LAT - 1)) begin
                            state_q <= StDone;
                        end else begin
                            drain_q <= drain_q + DrainW'(1);
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q   <= StIdle;
                        pic_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
            width_q  <= CNT_W'(IMG_W);
            height_q <= CNT_W'(IMG_H);
            pixcnt_q <= '0;
        end else begin
            if (done_set) begin
                done_q <= 1'b1;
            end else if (irqclr_wr && apb.PWDATA[IrqClrDoneBit]) begin
                done_q <= 1'b0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (irqclr_wr && apb.PWDATA[IrqClrErrBit]) begin
                err_q <= 1'b0;
            end
            if (ctrl_wr) begin
                irq_en_q <= apb.PWDATA[CtrlIrqEnBit];
            end
            if (cfg_wr && !busy) begin
                width_q  <= apb.PWDATA[CNT_W-1:0];
                height_q <= apb.PWDATA[CNT_W+15:16];
            end
            if (state_q == StClear) begin
                pixcnt_q <= '0;
            end else if (accept && (pixcnt_q != '1)) begin
                pixcnt_q <= pixcnt_q + PixW'(1);
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            unique case (reg_sel)
                RegCtrl:   prdata = pack_status(irq_en_q, err_q, done_q, busy);
                RegCfg: begin
                    prdata[CNT_W-1:0]     = width_q;
                    prdata[CNT_W+15:16]   = height_q;
                end
                RegIrqClr: prdata = '0;
                RegPixCnt: prdata[PixW-1:0] = pixcnt_q;
                default:   prdata = '0;
            endcase
        end
    end

    logic unused_apb;
    assign unused_apb = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA};

    assign apb.PRDATA  = prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

    assign pic_req_o   = pic_req_q;
    assign eng_clr_o   = eng_clr_q;
    assign irq_o       = done_q & irq_en_q;
    assign win_valid_o = accept & (row_o >= CNT_W'(K - 1)) & (col_o >= CNT_W'(K - 1));

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed and randomized checks of conv_seq_ctrl against a frame-level reference model.
module tb_conv_seq_ctrl;

    localparam int unsigned K        = 3;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned CNT_W    = 8;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic             irq_o, pic_req_o, pic_valid_i, eng_clr_o, win_valid_o;
    logic [CNT_W-1:0] row_o, col_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        exp_irq_en = 1'b0;
    logic        exp_err    = 1'b0;
    logic        exp_done   = 1'b0;
    logic [31:0] rd;

    conv_seq_ctrl_if apb ();

    conv_seq_ctrl #(
        .IMG_W    (28),
        .IMG_H    (28),
        .K        (K),
        .PIPE_LAT (PIPE_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .apb         (apb),
        .irq_o       (irq_o),
        .pic_req_o   (pic_req_o),
        .pic_valid_i (pic_valid_i),
        .eng_clr_o   (eng_clr_o),
        .win_valid_o (win_valid_o),
        .row_o       (row_o),
        .col_o       (col_o)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [31:0] st(input logic ie, input logic er, input logic dn,
                                       input logic by);
        return {28'b0, ie, er, dn, by};
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
    endtask

    task automatic apb_write(input logic [1:0] idx, input logic [31:0] data);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = {28'b0, idx, 2'b00};
        apb.PWDATA  = data;
        step();
        apb.PENABLE = 1'b1;
        step();
        bus_idle();
    endtask

    task automatic apb_read(input logic [1:0] idx, output logic [31:0] data);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = {28'b0, idx, 2'b00};
        step();
        apb.PENABLE = 1'b1;
        @(negedge HCLK);
        data = apb.PRDATA;
        step();
        bus_idle();
    endtask

    task automatic start_frame(input logic irq_en);
        apb_write(2'd0, {29'b0, irq_en, 2'b01});
        exp_irq_en = irq_en;
        chk("clr_pulse", 32'(eng_clr_o), 32'd1);
        chk("req_in_clear", 32'(pic_req_o), 32'd0);
        step();
        chk("clr_single", 32'(eng_clr_o), 32'd0);
        chk("req_latency", 32'(pic_req_o), 32'd1);
    endtask

    // Raster model: pixel n sits at (n / w, n % w); done lands PIPE_LAT+1 edges after last accept.
    task automatic stream_frame(input int w, input int h, input int pct);
        int   n = 0;
        int   guard = 0;
        logic v;
        while (n < w * h && guard < 4000) begin
            v = ($urandom_range(99) < pct);
            pic_valid_i = v;
            @(negedge HCLK);
            chk("req_stream", 32'(pic_req_o), 32'd1);
            chk("row", 32'(row_o), 32'(n / w));
            chk("col", 32'(col_o), 32'(n % w));
            chk("win", 32'(win_valid_o),
                32'(v && (n / w) >= int'(K) - 1 && (n % w) >= int'(K) - 1));
            if (v) n++;
            step();
            guard++;
        end
        pic_valid_i = 1'b0;
        chk("frame_len", 32'(n), 32'(w * h));
        chk("req_drop", 32'(pic_req_o), 32'd0);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        for (int k = 0; k < int'(PIPE_LAT) + 1; k++) begin
            @(negedge HCLK);
            chk("drain_status", apb.PRDATA, st(exp_irq_en, exp_err, exp_done, 1'b1));
            step();
        end
        exp_done = 1'b1;
        @(negedge HCLK);
        chk("done_status", apb.PRDATA, st(exp_irq_en, exp_err, 1'b1, 1'b0));
        chk("irq_level", 32'(irq_o), 32'(exp_irq_en));
        step();
        bus_idle();
        apb_read(2'd3, rd);
        chk("pixcnt", rd, 32'(w * h));
    endtask

    task automatic clear_flags();
        apb_write(2'd2, 32'h3);
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    initial begin
        int w, h;
        bus_idle();
        pic_valid_i = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_req", 32'(pic_req_o), 32'd0);
        chk("rst_clr", 32'(eng_clr_o), 32'd0);
        chk("rst_win", 32'(win_valid_o), 32'd0);
        chk("rst_rowcol", {16'b0, row_o, col_o}, 32'd0);
        chk("rst_pready", 32'(apb.PREADY), 32'd1);
        chk("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
        chk("rst_prdata", apb.PRDATA, 32'd0);
        HRESETn = 1'b1;
        step();
        apb_read(2'd1, rd);
        chk("rst_cfg", rd, 32'h001C_001C);
        apb_read(2'd0, rd);
        chk("rst_status", rd, 32'd0);

        // 1: 4x4 frame, continuous valid
        apb_write(2'd1, 32'h0004_0004);
        start_frame(1'b0);
        stream_frame(4, 4, 100);
        apb_read(2'd0, rd);
        chk("t1_status", rd, 32'h2);

        // 2: irq enabled, then W1C clear
        clear_flags();
        start_frame(1'b1);
        stream_frame(4, 4, 100);
        chk("t2_irq_set", 32'(irq_o), 32'd1);
        apb_write(2'd2, 32'h1);
        exp_done = 1'b0;
        chk("t2_irq_clr", 32'(irq_o), 32'd0);
        apb_read(2'd0, rd);
        chk("t2_status", rd, 32'h8);
        apb_read(2'd2, rd);
        chk("t2_irqclr_rd", rd, 32'd0);

        // 3: random 50% valid
        start_frame(1'b0);
        stream_frame(4, 4, 50);

        // 4: abort after 7 accepts
        clear_flags();
        start_frame(1'b0);
        pic_valid_i = 1'b1;
        for (int i = 0; i < 7; i++) step();
        pic_valid_i = 1'b0;
        @(negedge HCLK);
        chk("t4_pos", {16'b0, row_o, col_o}, 32'h0103);
        chk("t4_req_before", 32'(pic_req_o), 32'd1);
        step();
        apb_write(2'd0, 32'h2);
        exp_err = 1'b1;
        chk("t4_req_after", 32'(pic_req_o), 32'd0);
        apb_read(2'd0, rd);
        chk("t4_status", rd, 32'h4);
        apb_read(2'd3, rd);
        chk("t4_pixcnt", rd, 32'd7);

        // 5: zero width start, then start and CFG write while busy
        clear_flags();
        apb_write(2'd1, 32'h0004_0000);
        apb_write(2'd0, 32'h1);
        chk("t5_zero_req", 32'(pic_req_o), 32'd0);
        chk("t5_zero_clr", 32'(eng_clr_o), 32'd0);
        apb_read(2'd0, rd);
        chk("t5_zero_status", rd, 32'h4);
        clear_flags();
        apb_write(2'd1, 32'h0004_0004);
        start_frame(1'b0);
        apb_write(2'd0, 32'h1);
        exp_err = 1'b1;
        apb_write(2'd1, 32'h0008_0008);
        apb_read(2'd1, rd);
        chk("t5_cfg_locked", rd, 32'h0004_0004);
        apb_read(2'd0, rd);
        chk("t5_busy_status", rd, 32'h5);
        stream_frame(4, 4, 100);

        // 6: async reset mid-stream
        clear_flags();
        start_frame(1'b1);
        pic_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        HRESETn = 1'b0;
        #1;
        chk("t6_req", 32'(pic_req_o), 32'd0);
        chk("t6_clr", 32'(eng_clr_o), 32'd0);
        chk("t6_win", 32'(win_valid_o), 32'd0);
        chk("t6_rowcol", {16'b0, row_o, col_o}, 32'd0);
        chk("t6_irq", 32'(irq_o), 32'd0);
        pic_valid_i = 1'b0;
        step();
        HRESETn = 1'b1;
        exp_irq_en = 1'b0;
        exp_err    = 1'b0;
        exp_done   = 1'b0;
        step();
        chk("t6_no_clr", 32'(eng_clr_o), 32'd0);
        apb_read(2'd1, rd);
        chk("t6_cfg", rd, 32'h001C_001C);
        apb_read(2'd0, rd);
        chk("t6_status", rd, 32'd0);
        apb_write(2'd1, 32'h0004_0004);
        start_frame(1'b1);
        stream_frame(4, 4, 100);

        // 7: random geometry and valid pattern
        clear_flags();
        w = int'($urandom_range(6, 3));
        h = int'($urandom_range(5, 3));
        apb_write(2'd1, (32'(h) << 16) | 32'(w));
        start_frame(1'b0);
        stream_frame(w, h, 70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
